uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of stored bytes (power of two, 2..256).
REQ-002 SHALL have parameter IRQ_LEVEL, default 4, fill level that raises irq (1..DEPTH).
REQ-003 SHALL have port sysclk  input  1  system clock; one clock, all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port RX_STATUS  input  1  one-sysclk strobe from the receiver: byte complete.
REQ-006 SHALL have port RX_DATA  input  8  received byte, valid on the cycle RX_STATUS=1.
REQ-007 SHALL have port rd_en  input  1  CPU pop request.
REQ-008 SHALL have port rd_data  output  8  head-of-queue byte (first-word-fall-through).
REQ-009 SHALL have port empty  output  1  queue holds 0 bytes.
REQ-010 SHALL have port full  output  1  queue holds DEPTH bytes.
REQ-011 SHALL have port level  output  $clog2(DEPTH)+1  current byte count.
REQ-012 SHALL have port overrun  output  1  sticky: a byte was dropped.
REQ-013 SHALL have port clr_ovr  input  1  clears overrun.
REQ-014 SHALL have port irq  output  1  present only with UART_RX_FIFO_IRQ_EN (see Configuration).

Function
REQ-015 SHALL push RX_DATA at the sysclk edge where RX_STATUS=1 and full=0.
REQ-016 SHALL pop the head at the sysclk edge where rd_en=1 and empty=0; rd_data SHALL show the next entry the following cycle.
REQ-017 SHALL present rd_data = head entry whenever empty=0; value when empty=1 is the last popped byte, never X after reset.
REQ-018 SHALL ignore rd_en while empty=0 is false (no pointer or level change, no error flag).
REQ-019 SHALL, on RX_STATUS=1 while full=1 and rd_en=0, drop the byte and set overrun=1 the next cycle.
REQ-020 SHALL, on RX_STATUS=1 and rd_en=1 while full=1, pop and push in the same cycle; level stays DEPTH, overrun unaffected.
REQ-021 SHALL, on RX_STATUS=1 and rd_en=1 while empty=1, push only; level becomes 1, rd_data = RX_DATA next cycle.
REQ-022 SHALL update level, empty, full registered, consistent with pointers after every edge; latency write-to-empty=0 is one cycle.
REQ-023 SHALL wrap read/write pointers modulo DEPTH, using an extra pointer bit to distinguish full from empty.
REQ-024 SHALL clear overrun on clr_ovr=1; simultaneous new overrun event SHALL win (overrun stays 1).

Reset
REQ-025 SHALL on reset=0, immediately and regardless of sysclk: pointers=0, level=0, empty=1, full=0, overrun=0, rd_data=8'h00, irq=0.
REQ-026 SHALL discard queue contents on reset mid-operation; a RX_STATUS strobe coincident with reset release edge SHALL be pushed only if reset=1 at that edge.

Configuration
REQ-027 SHALL, with macro UART_RX_FIFO_IRQ_EN defined, drive irq registered: 1 when level >= IRQ_LEVEL or overrun=1, else 0.
REQ-028 SHALL, without UART_RX_FIFO_IRQ_EN, omit port irq and its logic; all other behaviour identical.

Structure
REQ-029 SHALL take byte width (UART_DATA_W=8) and default DEPTH from shared package uart_pkg.
REQ-030 SHALL place storage in sub-module uart_rx_fifo_ram (one write port, asynchronous read port, no reset on array).

Verification
REQ-031 Reset, then 3 strobes 8'hA1,8'hB2,8'hC3 -> level=3, rd_data=8'hA1; three rd_en pops yield A1,B2,C3 then empty=1.
REQ-032 DEPTH=8: push 8'h00..8'h07 -> full=1; strobe 8'hFF alone -> overrun=1, level=8, pops return 00..07.
REQ-033 Full queue, RX_STATUS=1 (8'h55) with rd_en=1 -> level stays 8, overrun=0, last pop after drain returns 8'h55.
REQ-034 Empty queue, RX_STATUS=1 (8'h3C) with rd_en=1 -> level=1, rd_data=8'h3C next cycle.
REQ-035 overrun=1, clr_ovr=1 together with drop event -> overrun remains 1; clr_ovr alone next cycle -> 0.
REQ-036 With UART_RX_FIFO_IRQ_EN, IRQ_LEVEL=4: 4th push -> irq=1; one pop -> irq=0; assert reset mid-fill -> all outputs per REQ-025.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART byte width and default receive queue depth
package uart_pkg;

  localparam int UART_DATA_W   = 8;
  localparam int UART_RX_DEPTH = 8;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo_ram.sv
// rtl/uart_rx_fifo_ram.sv - receive queue storage: one write port, asynchronous read port
module uart_rx_fifo_ram
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_DEPTH,
  parameter int W     = UART_DATA_W
) (
  input  logic                     sysclk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  // Contents are deliberately not reset; the top masks reads while the queue is empty.
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge sysclk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : uart_rx_fifo_ram

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through byte queue from UART receiver to CPU
// Optional registered irq output when UART_RX_FIFO_IRQ_EN is defined.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH     = UART_RX_DEPTH,
  parameter int IRQ_LEVEL = 4
) (
  input  logic                     sysclk,
  input  logic                     reset,
  input  logic                     RX_STATUS,
  input  logic [UART_DATA_W-1:0]   RX_DATA,
  input  logic                     rd_en,
  output logic [UART_DATA_W-1:0]   rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overrun,
  input  logic                     clr_ovr
`ifdef UART_RX_FIFO_IRQ_EN
  ,
  output logic                     irq
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic [PW-1:0] level_q, level_nxt;
  logic          empty_q, full_q, overrun_q;
  logic          empty_nxt, full_nxt, overrun_nxt;
  uart_byte_t    head, last_pop_q;
  logic          do_push, do_pop, drop;

  // A full queue still accepts a byte when the CPU pops in the same cycle.
  assign do_pop  = rd_en & ~empty_q;
  assign do_push = RX_STATUS & (~full_q | do_pop);
  assign drop    = RX_STATUS & full_q & ~rd_en;

  always_comb begin
    wr_ptr_nxt = wr_ptr_q;
    rd_ptr_nxt = rd_ptr_q;
    if (do_push) begin
      wr_ptr_nxt = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_nxt = rd_ptr_q + PW'(1);
    end
    level_nxt = wr_ptr_nxt - rd_ptr_nxt;
    empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);
    full_nxt  = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
    // A drop in the same cycle as clr_ovr keeps the flag set.
    overrun_nxt = overrun_q;
    if (drop) begin
      overrun_nxt = 1'b1;
    end else if (clr_ovr) begin
      overrun_nxt = 1'b0;
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overrun_q  <= 1'b0;
      last_pop_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_nxt;
      rd_ptr_q  <= rd_ptr_nxt;
      level_q   <= level_nxt;
      empty_q   <= empty_nxt;
      full_q    <= full_nxt;
      overrun_q <= overrun_nxt;
      if (do_pop) begin
        last_pop_q <= head;
      end
    end
  end

  uart_rx_fifo_ram #(
    .DEPTH (DEPTH),
    .W     (UART_DATA_W)
  ) u_ram (
    .sysclk (sysclk),
    .we     (do_push),
    .waddr  (wr_ptr_q[AW-1:0]),
    .wdata  (RX_DATA),
    .raddr  (rd_ptr_q[AW-1:0]),
    .rdata  (head)
  );

  // While empty, hold the last popped byte so rd_data never shows stale RAM.
  assign rd_data = empty_q ? last_pop_q : head;
  assign empty   = empty_q;
  assign full    = full_q;
  assign level   = level_q;
  assign overrun = overrun_q;

`ifdef UART_RX_FIFO_IRQ_EN
  localparam logic [PW-1:0] IRQ_LVL = PW'(IRQ_LEVEL);

  logic irq_q;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (level_nxt >= IRQ_LVL) | overrun_nxt;
    end
  end

  assign irq = irq_q;
`endif

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo (directed cases then random traffic)
module tb_uart_rx_fifo;

  localparam int DEPTH     = 8;
  localparam int IRQ_LEVEL = 4;

  logic       sysclk    = 1'b0;
  logic       reset     = 1'b1;
  logic       RX_STATUS = 1'b0;
  logic [7:0] RX_DATA   = 8'h00;
  logic       rd_en     = 1'b0;
  logic       clr_ovr   = 1'b0;
  logic [7:0] rd_data;
  logic       empty, full, overrun;
  logic [3:0] level;
`ifdef UART_RX_FIFO_IRQ_EN
  logic       irq;
`endif

  int         n_cmp = 0;
  int         n_bad = 0;

  // Reference model: byte count, sticky flag, last byte handed to the CPU.
  logic [7:0] exp_q[$];
  int         m_lvl  = 0;
  bit         m_ovr  = 1'b0;
  logic [7:0] m_last = 8'h00;

  always #5 sysclk = ~sysclk;

  uart_rx_fifo #(
    .DEPTH     (DEPTH),
    .IRQ_LEVEL (IRQ_LEVEL)
  ) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .RX_STATUS (RX_STATUS),
    .RX_DATA   (RX_DATA),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .level     (level),
    .overrun   (overrun),
    .clr_ovr   (clr_ovr)
`ifdef UART_RX_FIFO_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every CPU pop the DUT accepts must deliver the oldest expected byte.
  always @(negedge sysclk) begin : monitor
    logic [7:0] b;
    if (reset && rd_en && !empty) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop_data: DUT popped 'h%0h but scoreboard is empty at %0t", rd_data, $time);
      end else begin
        b = exp_q.pop_front();
        chk("pop_data", int'(rd_data), int'(b));
        m_last = b;
      end
    end
  end

  task automatic check_state();
    chk("level", int'(level), m_lvl);
    chk("empty", int'(empty), int'(m_lvl == 0));
    chk("full", int'(full), int'(m_lvl == DEPTH));
    chk("overrun", int'(overrun), int'(m_ovr));
    if (m_lvl > 0 && exp_q.size() > 0) chk("head", int'(rd_data), int'(exp_q[0]));
    else if (m_lvl == 0) chk("rd_data_idle", int'(rd_data), int'(m_last));
`ifdef UART_RX_FIFO_IRQ_EN
    chk("irq", int'(irq), int'(m_lvl >= IRQ_LEVEL || m_ovr));
`endif
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic cycle(input bit st, input logic [7:0] d, input bit rd, input bit clr);
    bit pop, push, drop;
    RX_STATUS = st;
    RX_DATA   = d;
    rd_en     = rd;
    clr_ovr   = clr;
    @(posedge sysclk);
    if (reset) begin
      pop  = rd && (m_lvl > 0);
      push = st && ((m_lvl < DEPTH) || pop);
      drop = st && (m_lvl == DEPTH) && !rd;
      m_lvl = m_lvl + int'(push) - int'(pop);
      if (push) exp_q.push_back(d);
      if (drop) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
    end
    #1;
    check_state();
  endtask

  task automatic drain();
    for (int g = 0; g < DEPTH + 1 && m_lvl > 0; g++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, base + 8'(i), 1'b0, 1'b0);
  endtask

  // Assert reset away from any clock edge and check the outputs before the next edge.
  task automatic async_reset();
    reset     = 1'b0;
    RX_STATUS = 1'b0;
    rd_en     = 1'b0;
    clr_ovr   = 1'b0;
    exp_q.delete();
    m_lvl  = 0;
    m_ovr  = 1'b0;
    m_last = 8'h00;
    #1;
    chk("rst_level", int'(level), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_rd_data", int'(rd_data), 0);
`ifdef UART_RX_FIFO_IRQ_EN
    chk("rst_irq", int'(irq), 0);
`endif
  endtask

  initial begin : stimulus
    int pst, prd;
    #1;
    async_reset();
    @(posedge sysclk);
    #1;
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    reset = 1'b1;

    cycle(1'b1, 8'hA1, 1'b0, 1'b0);
    cycle(1'b1, 8'hB2, 1'b0, 1'b0);
    cycle(1'b1, 8'hC3, 1'b0, 1'b0);
    chk("basic_level", int'(level), 3);
    chk("basic_head", int'(rd_data), 'hA1);
    repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("basic_empty", int'(empty), 1);
    chk("basic_last", int'(rd_data), 'hC3);

    fill(8'h00);
    chk("fill_full", int'(full), 1);
    cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("drop_overrun", int'(overrun), 1);
    chk("drop_level", int'(level), 8);
    drain();
    chk("drop_last", int'(rd_data), 'h07);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pop_empty_level", int'(level), 0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_overrun", int'(overrun), 0);

    fill(8'h10);
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    chk("full_pushpop_level", int'(level), 8);
    chk("full_pushpop_ovr", int'(overrun), 0);
    drain();
    chk("full_pushpop_last", int'(rd_data), 'h55);

    cycle(1'b1, 8'h3C, 1'b1, 1'b0);
    chk("empty_pushpop_level", int'(level), 1);
    chk("empty_pushpop_data", int'(rd_data), 'h3C);
    drain();

    fill(8'h20);
    cycle(1'b1, 8'hE0, 1'b0, 1'b0);
    cycle(1'b1, 8'hE1, 1'b0, 1'b1);
    chk("clr_vs_drop", int'(overrun), 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_alone", int'(overrun), 0);
    drain();

    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
`ifdef UART_RX_FIFO_IRQ_EN
    chk("irq_below", int'(irq), 0);
`endif
    cycle(1'b1, 8'h43, 1'b0, 1'b0);
`ifdef UART_RX_FIFO_IRQ_EN
    chk("irq_at_level", int'(irq), 1);
`endif
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
`ifdef UART_RX_FIFO_IRQ_EN
    chk("irq_after_pop", int'(irq), 0);
`endif
    cycle(1'b1, 8'h44, 1'b0, 1'b0);
    async_reset();
    cycle(1'b1, 8'h66, 1'b0, 1'b0);
    reset = 1'b1;
    cycle(1'b1, 8'h99, 1'b0, 1'b0);
    chk("release_push_level", int'(level), 1);
    chk("release_push_data", int'(rd_data), 'h99);
    drain();

    for (int ph = 0; ph < 3; ph++) begin
      pst = 75 - 25 * ph;
      prd = 25 + 25 * ph;
      for (int n = 0; n < 300; n++) begin
        if (ph == 1 && $urandom_range(199) == 0) begin
          async_reset();
          cycle(1'b0, 8'h00, 1'b0, 1'b0);
          reset = 1'b1;
        end
        cycle(bit'($urandom_range(99) < pst), 8'($urandom),
              bit'($urandom_range(99) < prd), bit'($urandom_range(99) < 5));
      end
    end
    drain();
    chk("final_empty", int'(empty), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_uart_rx_fifo
